mem_a_ctrl: RTL and testbench
=============================

MEM_A_CTRL -- requirements
Module: mem_a_ctrl

Interface
REQ-001 Parameter BITS_AB, default 8, operand element width in bits.
REQ-002 Parameter DIM, default 8, array dimension: rows per matrix and elements per row.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin one load-then-stream pass; sampled only in IDLE.
REQ-006 row_valid  input  1  producer has a row on row_data.
REQ-007 row_data  input  signed [BITS_AB-1:0] x DIM  one matrix row, element 0 at index 0.
REQ-008 stall  input  1  downstream hold request; freezes streaming.
REQ-009 row_ready  output  1  controller accepts a row this cycle.
REQ-010 Ain  output  signed [BITS_AB-1:0] x DIM  row data to the A-operand skew memory.
REQ-011 Arow  output  [$clog2(DIM)-1:0]  destination row index for the write.
REQ-012 WrEn  output  1  write strobe to the skew memory.
REQ-013 en  output  1  shift enable to the skew memory.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse marking pass completion.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, STREAM and DONE.
REQ-017 Transitions:
- IDLE->LOAD when start=1.
- LOAD->STREAM on acceptance of row DIM-1.
- STREAM->DONE when the stream counter reaches 3*DIM-1 enabled cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-018 row_ready SHALL be 1 exactly when state is LOAD (combinational from state).
REQ-019 A row SHALL be accepted in a cycle with row_valid=1 and row_ready=1; WrEn SHALL equal that product combinationally.
REQ-020 Ain SHALL pass row_data through combinationally; Arow SHALL equal the registered row counter.
REQ-021 The row counter SHALL start at 0 on entering LOAD, increment by 1 per accepted row and never wrap within a pass; rows are written in order 0..DIM-1.
REQ-022 A LOAD cycle with row_valid=0 SHALL hold the row counter and drive WrEn=0; LOAD has no timeout.
REQ-023 en SHALL be 1 exactly when state is STREAM and stall=0; it SHALL be 0 in IDLE, LOAD and DONE, so writes and shifts never coincide.
REQ-024 The stream counter (width $clog2(3*DIM)) SHALL clear on entering STREAM and increment only on cycles with en=1.
REQ-025 The transition to DONE SHALL occur on the clock edge at which the 3*DIM-1th en=1 cycle completes; stall cycles SHALL not count.
REQ-026 done SHALL be 1 exactly when state is DONE; busy SHALL be 1 in LOAD, STREAM and DONE.
REQ-027 start asserted while busy=1 SHALL be ignored and not queued.
REQ-028 start sampled in the DONE cycle SHALL be ignored; a new pass begins only from IDLE.
REQ-029 stall asserted outside STREAM SHALL have no effect.
REQ-030 Minimum pass latency, from the start edge to the done pulse, SHALL be DIM + (3*DIM-1) + 1 cycles with row_valid held at 1 and stall held at 0.

Reset
REQ-031 While rst_n=0, state SHALL be IDLE and both counters 0.
REQ-032 While rst_n=0, outputs SHALL be row_ready=0, WrEn=0, en=0, Arow=0, busy=0 and done=0, independent of clk.
REQ-033 Reset asserted mid-pass SHALL abandon the pass immediately, with no done pulse.
REQ-034 After release from a mid-pass reset, the controller SHALL wait in IDLE for a new start.

Verification
REQ-035 DIM=8, start pulse, row_valid held at 1 -> WrEn high for 8 consecutive cycles with Arow 0..7.
REQ-036 Continuing REQ-035 -> en high for 23 consecutive cycles, then done=1 for one cycle, then busy=0; done arrives 32 cycles after the start edge.
REQ-037 row_valid deasserted for 3 cycles after row 3 -> Arow holds at 4 with WrEn=0; all 8 rows are still written in order.
REQ-038 stall=1 for 5 cycles mid-STREAM -> en=0 for those cycles; done is delayed by exactly 5 cycles; en stays high for 23 cycles in total.
REQ-039 start re-pulsed during LOAD and again during the DONE cycle -> no effect; a single pass; IDLE is reached afterwards.
REQ-040 rst_n=0 asynchronously during STREAM -> en, busy and done drop to 0 without waiting for a clock edge; after release, the next start begins loading at Arow=0.

Source files
------------

// File: rtl/mem_a_ctrl.sv
// A-operand load/stream controller: loads DIM rows into the skew memory, then
// enables 3*DIM-1 shift cycles (stall-aware) and pulses done once per pass.
module mem_a_ctrl #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      row_valid,
  input  logic signed [BITS_AB-1:0] row_data [DIM],
  input  logic                      stall,
  output logic                      row_ready,
  output logic signed [BITS_AB-1:0] Ain [DIM],
  output logic [$clog2(DIM)-1:0]    Arow,
  output logic                      WrEn,
  output logic                      en,
  output logic                      busy,
  output logic                      done
);

  localparam int RW = $clog2(DIM);
  localparam int SW = $clog2(3 * DIM);
  localparam logic [RW-1:0] ROW_LAST  = RW'(DIM - 1);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [SW-1:0] BEAT_LAST = SW'(3 * DIM - 2);
  localparam logic [SW-1:0] BEAT_ONE  = SW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [RW-1:0]   row_cnt_r;
  logic [SW-1:0]   beat_cnt_r;
  logic            last_row_s;
  logic            last_beat_s;

  assign last_row_s  = (row_cnt_r == ROW_LAST);
  assign last_beat_s = (beat_cnt_r == BEAT_LAST);
  assign Ain         = row_data;
  assign Arow        = row_cnt_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = LOAD;
        else       state_nxt_s = IDLE;
      end
      LOAD: begin
        if (WrEn && last_row_s) state_nxt_s = STREAM;
        else                    state_nxt_s = LOAD;
      end
      STREAM: begin
        if (en && last_beat_s) state_nxt_s = DONE;
        else                   state_nxt_s = STREAM;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode; WrEn and en are mutually exclusive by state
  always_comb begin
    row_ready = 1'b0;
    WrEn      = 1'b0;
    en        = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_r)
      IDLE: busy = 1'b0;
      LOAD: begin
        row_ready = 1'b1;
        WrEn      = row_valid;
      end
      STREAM:  en   = ~stall;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Row and beat counters; the row counter parks on DIM-1 instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_r  <= {RW{1'b0}};
      beat_cnt_r <= {SW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) row_cnt_r <= {RW{1'b0}};
        end
        LOAD: begin
          if (WrEn) begin
            if (last_row_s) beat_cnt_r <= {SW{1'b0}};
            else            row_cnt_r  <= row_cnt_r + ROW_ONE;
          end
        end
        STREAM: begin
          if (en) beat_cnt_r <= beat_cnt_r + BEAT_ONE;
        end
        default: begin
          row_cnt_r  <= row_cnt_r;
          beat_cnt_r <= beat_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_a_ctrl.sv
// Self-checking bench for mem_a_ctrl: pass-level behavioural model compared
// every cycle, plus directed passes with literal latency/count expectations.
module tb_mem_a_ctrl;
  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int RW      = $clog2(DIM);

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      start = 1'b0;
  logic                      row_valid = 1'b0;
  logic signed [BITS_AB-1:0] row_data [DIM];
  logic                      stall = 1'b0;
  logic                      row_ready;
  logic signed [BITS_AB-1:0] Ain [DIM];
  logic [RW-1:0]             Arow;
  logic                      WrEn;
  logic                      en;
  logic                      busy;
  logic                      done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_a_ctrl #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row_valid(row_valid),
    .row_data(row_data), .stall(stall), .row_ready(row_ready), .Ain(Ain),
    .Arow(Arow), .WrEn(WrEn), .en(en), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pass-level model: phase 0 idle, 1 loading, 2 streaming, 3 done pulse
  int m_phase = 0;
  int m_rows  = 0;
  int m_beats = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_rows  <= 0;
      m_beats <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase <= 1; m_rows <= 0; end
        1: if (row_valid) begin
             m_rows <= m_rows + 1;
             if (m_rows + 1 == DIM) begin m_phase <= 2; m_beats <= 0; end
           end
        2: if (!stall) begin
             m_beats <= m_beats + 1;
             if (m_beats + 1 == 3 * DIM - 1) m_phase <= 3;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  bit ain_ok;
  always @(negedge clk) begin
    ain_ok = 1'b1;
    for (int j = 0; j < DIM; j++) if (Ain[j] !== row_data[j]) ain_ok = 1'b0;
    check("row_ready", row_ready, m_phase == 1);
    check("WrEn", WrEn, (m_phase == 1) && row_valid);
    check("en", en, (m_phase == 2) && !stall);
    check("busy", busy, m_phase != 0);
    check("done", done, m_phase == 3);
    check("Arow", Arow, (m_rows > DIM - 1) ? DIM - 1 : m_rows);
    check("Ain", ain_ok, 1'b1);
  end

  task automatic set_data(input int seed);
    for (int j = 0; j < DIM; j++) row_data[j] = BITS_AB'(seed * 7 + j * 3 - 20);
  endtask

  // One full pass with optional valid gap, stall burst and stray start pulses
  task automatic run_pass(input int gap_row, input int gap_len, input int stall_at,
                          input int stall_len, input bit repulse, input int exp_lat);
    int k, wr, beats, gapd, stld, lat, wr_first, wr_last, en_first, en_last;
    bit seen_done;
    k = 0; wr = 0; beats = 0; gapd = 0; stld = 0; lat = -1;
    wr_first = -1; wr_last = -1; en_first = -1; en_last = -1; seen_done = 1'b0;
    @(posedge clk);
    #1 start = 1'b1; row_valid = 1'b1; stall = 1'b0;
    @(posedge clk);
    while (!seen_done && k < 200) begin
      #1 k++;
      start = repulse && (k == 3 || k == exp_lat);
      row_valid = !(wr == gap_row + 1 && gapd < gap_len);
      if (!row_valid) gapd++;
      if (repulse) stall = (wr < DIM);
      else         stall = (stall_len > 0) && (beats == stall_at) && (stld < stall_len);
      if (stall && !repulse) stld++;
      set_data(k);
      @(negedge clk);
      if (WrEn) begin
        check("wr_order", Arow, wr);
        wr++;
        if (wr_first < 0) wr_first = k;
        wr_last = k;
      end
      if (!row_valid && row_ready) check("arow_hold", Arow, gap_row + 1);
      if (en) begin
        beats++;
        if (en_first < 0) en_first = k;
        en_last = k;
      end
      if (done) begin seen_done = 1'b1; lat = k; end
      @(posedge clk);
    end
    #1 start = 1'b0; row_valid = 1'b0; stall = 1'b0;
    check("done_seen", seen_done, 1'b1);
    check("latency", lat, exp_lat);
    check("rows_written", wr, DIM);
    check("wr_span", wr_last - wr_first, DIM - 1 + gap_len);
    check("en_total", beats, 3 * DIM - 1);
    check("en_span", en_last - en_first, 3 * DIM - 2 + stall_len);
    repeat (4) begin
      @(negedge clk);
      check("idle_after", busy, 1'b0);
      check("no_done_after", done, 1'b0);
    end
  endtask

  initial begin
    set_data(0);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_row_ready", row_ready, 1'b0);
    check("rst_Arow", Arow, 0);
    check("rst_en", en, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_pass(-1, 0, -1, 0, 1'b0, 32);   // clean pass
    run_pass(3, 3, -1, 0, 1'b0, 35);    // valid gap after row 3
    run_pass(-1, 0, 10, 5, 1'b0, 37);   // 5-cycle stall mid-stream
    run_pass(-1, 0, -1, 0, 1'b1, 32);   // stray starts + stall during load

    // Asynchronous reset in the middle of STREAM
    @(posedge clk);
    #1 start = 1'b1; row_valid = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_rst_en", en, 1'b1);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_en", en, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_done", done, 1'b0);
    check("async_Arow", Arow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; row_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("wait_idle", busy, 1'b0);
    end
    run_pass(-1, 0, -1, 0, 1'b0, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
